// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared types and constants for the instruction prefetch queue
package fetch_queue_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0100_0000;
  typedef logic [XLEN-1:0] arch_reg_t;
  typedef struct packed {
    arch_reg_t pc;
    arch_reg_t instr;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// sync_fifo: power-of-two circular FIFO with flush and a head read straight from storage
module sync_fifo
  import fetch_queue_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  // pointer and occupancy update; flush empties the queue outright
  always_comb begin
    wr_d    = flush ? '0 : wr_q + AW'(push);
    rd_d    = flush ? '0 : rd_q + AW'(pop);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  // control state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
  // storage write; contents need no reset since count gates visibility
  always_ff @(posedge clock) begin
    if (push && !flush) mem_q[wr_q] <= push_data;
  end
  assign head  = mem_q[rd_q];
  assign count = count_q;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction prefetcher with credit-limited issue and redirect flush
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        req_valid,
  output logic [31:0] req_addr,
  input  logic        req_ready,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);
  arch_reg_t     fetch_pc_q, fetch_pc_d, tag_head;
  logic [CW-1:0] inflight_q, inflight_d, discard_q, discard_d, count, tag_count;
  logic          hs, keep, pop;
  fq_entry_t     head, push_e;
  // issue credit, response routing and next-state for the fetch pointer and counters
  always_comb begin
    req_valid  = !reset && !redirect_valid && (({1'b0, count} + {1'b0, inflight_q}) < LIMIT);
    hs         = req_valid && req_ready;
    keep       = resp_valid && !redirect_valid && discard_q == '0;
    pop        = out_valid && out_ready && !redirect_valid;
    fetch_pc_d = redirect_valid ? {redirect_pc[31:2], 2'b00} : hs ? fetch_pc_q + 32'd4 : fetch_pc_q;
    inflight_d = inflight_q + CW'(hs) - CW'(resp_valid);
    discard_d  = redirect_valid ? inflight_q - CW'(resp_valid)
                                : discard_q - CW'(resp_valid && discard_q != '0);
  end
  // fetch pointer and credit/discard counters
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end
  assign push_e    = '{pc: tag_head, instr: resp_data};
  assign req_addr  = fetch_pc_q;
  assign out_valid = !reset && count != '0;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  sync_fifo #(.W(32), .DEPTH(DEPTH)) u_tag (
    .clock(clock), .reset(reset), .push(hs), .push_data(fetch_pc_q), .pop(keep),
    .flush(redirect_valid), .head(tag_head), .count(tag_count)
  );
  sync_fifo #(.W($bits(fq_entry_t)), .DEPTH(DEPTH)) u_entry (
    .clock(clock), .reset(reset), .push(keep), .push_data(push_e), .pop(pop),
    .flush(redirect_valid), .head(head), .count(count)
  );
  // occupancy and credit invariants
  always @(posedge clock) begin
    if (!reset) begin
      assert (count <= CW'(DEPTH));
      assert (discard_q <= inflight_q && inflight_q <= CW'(DEPTH));
      assert (!(resp_valid && inflight_q == '0));
      assert (tag_count == inflight_q - discard_q);
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table vectors, directed corner sequences and a scoreboarded random phase
module tb_fetch_queue;
  import fetch_queue_pkg::*;
  localparam logic [31:0] RPC = 32'h0100_0000;
  logic        clock = 0, reset = 1, redirect_valid = 0, req_ready = 1, resp_valid = 0, out_ready = 1;
  logic [31:0] redirect_pc = '0, resp_data = '0;
  logic        req_valid, out_valid;
  logic [31:0] req_addr, out_pc, out_instr;
  typedef struct { int due; logic [31:0] addr; bit live; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; int rdy; } exp_t;
  typedef struct { logic out_ready; logic exp_ov; logic [7:0] pc_off; logic exp_rv; logic [7:0] ra_off; } vec_t;
  pend_t       pend[$];
  exp_t        expq[$];
  vec_t        tbl[16];
  vec_t        tv;
  bit          tv_on = 0, popped = 0;
  logic [31:0] last_pop_pc = '0, mpc = RPC;
  int          cyc = 0, lat = 1, lastdue = 0, checks = 0, errors = 0;

  fetch_queue #(.DEPTH(4), .RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    bit got, live, ev, placed;
    int d;
    got = 0;
    live = 0;
    resp_valid = 0;
    resp_data = '0;
    if (!reset && pend.size() > 0 && pend[0].due == cyc) begin
      got = 1;
      live = pend[0].live;
      resp_valid = 1;
      resp_data = instr_of(pend[0].addr);
      pend.delete(0);
    end
    @(negedge clock);
    if (reset) begin
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_req_valid", 32'(req_valid), 32'(0));
    end else begin
      if (tv_on) begin
        check("tv_out_valid", 32'(out_valid), 32'(tv.exp_ov));
        if (tv.exp_ov) check("tv_out_pc", out_pc, RPC + 32'(tv.pc_off));
        check("tv_req_valid", 32'(req_valid), 32'(tv.exp_rv));
        if (tv.exp_rv) check("tv_req_addr", req_addr, RPC + 32'(tv.ra_off));
      end
      ev = expq.size() > 0 && expq[0].rdy >= 0 && expq[0].rdy <= cyc;
      check("out_valid", 32'(out_valid), 32'(ev));
      if (out_valid && out_ready && !redirect_valid) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_empty: got pc %h expected no entry (cycle %0d)", out_pc, cyc);
        end else begin
          check("out_pc", out_pc, expq[0].pc);
          check("out_instr", out_instr, expq[0].instr);
          popped = 1;
          last_pop_pc = out_pc;
          expq.delete(0);
        end
      end
      if (redirect_valid) begin
        check("redir_req_valid", 32'(req_valid), 32'(0));
        expq.delete();
        foreach (pend[i]) pend[i].live = 0;
        mpc = {redirect_pc[31:2], 2'b00};
      end else if (got && live) begin
        placed = 0;
        foreach (expq[i]) if (!placed && expq[i].rdy < 0) begin
          expq[i].rdy = cyc + 1;
          placed = 1;
        end
      end
      if (req_valid && req_ready) begin
        check("req_addr", req_addr, mpc);
        d = cyc + lat;
        if (d <= lastdue) d = lastdue + 1;
        lastdue = d;
        pend.push_back('{due: d, addr: mpc, live: 1'b1});
        expq.push_back('{pc: mpc, instr: instr_of(mpc), rdy: -1});
        mpc += 32'd4;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset = 1;
    redirect_valid = 0;
    pend.delete();
    expq.delete();
    mpc = RPC;
    repeat (n) step();
    reset = 0;
  endtask

  task automatic wait_out(input logic [31:0] exp_pc, input string name);
    popped = 0;
    for (int i = 0; i < 30 && !popped; i++) step();
    if (!popped) begin
      checks++;
      errors++;
      $display("FAIL %s: got no entry within 30 cycles expected pc %h", name, exp_pc);
    end else check(name, last_pop_pc, exp_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h04};
    tbl[2]  = '{1'b1, 1'b1, 8'h00, 1'b1, 8'h08};
    tbl[3]  = '{1'b1, 1'b1, 8'h04, 1'b1, 8'h0C};
    tbl[4]  = '{1'b1, 1'b1, 8'h08, 1'b1, 8'h10};
    tbl[5]  = '{1'b0, 1'b1, 8'h0C, 1'b1, 8'h14};
    tbl[6]  = '{1'b0, 1'b1, 8'h0C, 1'b1, 8'h18};
    tbl[7]  = '{1'b0, 1'b1, 8'h0C, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 1'b1, 8'h0C, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 1'b1, 8'h0C, 1'b0, 8'h00};
    tbl[10] = '{1'b1, 1'b1, 8'h0C, 1'b0, 8'h00};
    tbl[11] = '{1'b1, 1'b1, 8'h10, 1'b1, 8'h1C};
    tbl[12] = '{1'b1, 1'b1, 8'h14, 1'b1, 8'h20};
    tbl[13] = '{1'b1, 1'b1, 8'h18, 1'b1, 8'h24};
    tbl[14] = '{1'b1, 1'b1, 8'h1C, 1'b1, 8'h28};
    tbl[15] = '{1'b1, 1'b1, 8'h20, 1'b1, 8'h2C};

    lat = 1;
    do_reset(2);
    for (int i = 0; i < 16; i++) begin
      out_ready = tbl[i].out_ready;
      tv = tbl[i];
      tv_on = 1;
      step();
    end
    tv_on = 0;

    lat = 3;
    out_ready = 1;
    do_reset(2);
    repeat (3) step();
    redirect_valid = 1;
    redirect_pc = 32'h0100_0102;
    step();
    redirect_valid = 0;
    check("t3_discard", 32'(dut.discard_q), 32'(pend.size()));
    wait_out(32'h0100_0100, "t3_first_pc");

    lat = 2;
    do_reset(2);
    repeat (6) step();
    redirect_valid = 1;
    redirect_pc = 32'h0100_0400;
    step();
    redirect_valid = 0;
    check("t4_discard", 32'(dut.discard_q), 32'(pend.size()));
    check("t4_inflight", 32'(dut.inflight_q), 32'(pend.size()));
    wait_out(32'h0100_0400, "t4_first_pc");

    do_reset(2);
    repeat (4) step();
    redirect_valid = 1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect_pc = 32'h0000_0300;
    step();
    redirect_valid = 0;
    wait_out(32'h0000_0300, "t5_first_pc");

    do_reset(2);
    out_ready = 0;
    repeat (4) step();
    do_reset(1);
    step();
    out_ready = 1;
    wait_out(RPC, "t6_restart_pc");

    do_reset(2);
    for (int i = 0; i < 400; i++) begin
      req_ready = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      redirect_valid = ($urandom_range(19) == 0);
      redirect_pc = $urandom;
      lat = $urandom_range(3, 1);
      step();
    end
    redirect_valid = 0;
    req_ready = 1;
    out_ready = 1;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch queue between instruction memory and decode, for the pipelined core.
- Issues sequential word fetch requests ahead of decode and buffers returned {pc, instr} pairs in a FIFO.
- Presents entries to decode via valid/ready.
- Flushes all buffered and in-flight fetches on a control-flow redirect from execute.

Parameters:
DEPTH, 4, number of FIFO entries and maximum fetches in flight (power of two, at least 2)
RESET_PC, 32'h0100_0000, first fetch address after reset

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high reset
redirect_valid  in  1  execute requests a PC change this cycle
redirect_pc  in  32  new fetch address; bits [1:0] are ignored and forced to 0
req_valid  out  1  fetch request to imem
req_addr  out  32  word-aligned fetch address
req_ready  in  1  imem accepts the request this cycle
resp_valid  in  1  imem returns data, in request order, any latency of 1 cycle or more
resp_data  in  32  returned instruction word
out_valid  out  1  FIFO head is valid
out_pc  out  32  PC of the head entry
out_instr  out  32  instruction of the head entry
out_ready  in  1  decode consumes the head entry this cycle

Behaviour:
- Interface contract: one clock; reset is synchronous and active-high (ports clock, reset).
- Reset values:
  - fetch_pc = RESET_PC; count = 0; inflight = 0; discard = 0.
  - out_valid = 0; req_valid = 0 during the reset cycle.
  - Reset asserted mid-operation drops all state, including outstanding responses. The imem is reset on the same edge.
- Request issue:
  - req_valid = !reset && !redirect_valid && (count + inflight < DEPTH).
  - req_addr = fetch_pc.
  - On a handshake (req_valid && req_ready): fetch_pc += 4 and inflight += 1.
  - fetch_pc wraps modulo 2^32.
  - The first request appears in the cycle after reset deasserts. Fetch-to-out_valid latency is imem latency + 1 cycle (registered FIFO write).
- Response handling:
  - A resp_valid with discard > 0 is dropped: discard -= 1, inflight -= 1.
  - Otherwise {pc_tag, resp_data} is pushed and inflight -= 1.
  - pc_tag comes from a PC tag queue of DEPTH entries, written at request issue and popped at response.
  - Responses never overflow the FIFO: the credit check at issue guarantees space.
- Output: out_valid = (count != 0). Pop on out_valid && out_ready. A push and a pop in the same cycle leave count unchanged.
- Redirect (has priority over all other events in its cycle):
  - FIFO count becomes 0 and the PC tag queue is cleared.
  - fetch_pc becomes {redirect_pc[31:2], 2'b00}.
  - discard becomes inflight minus any response that is discarded in this same cycle; that response counts as in-flight.
  - No request is issued in the redirect cycle. A pop in the same cycle is ignored.
  - out_valid is 0 in the cycle after the redirect.
  - The next request issues at the new PC in the cycle after the redirect.
- Back-to-back redirects: each one re-targets fetch_pc. discard accumulates correctly because inflight only drops on responses.
- FIFO full (count == DEPTH): no requests issue. Sustained out_ready = 0 stalls with no loss.
- Occupancy and outstanding responses are never allowed to exceed DEPTH.
- Assertions: count <= DEPTH; discard <= inflight <= DEPTH; no resp_valid when inflight == 0.

Decomposition:
- Package fetch_queue_pkg holds:
  - fq_entry_t {pc, instr}, 32+32 bits;
  - RESET_PC_DEFAULT;
  - the arch_reg alias shared with the core.
- One sub-module, sync_fifo:
  - parameterised on width and depth;
  - push, pop and flush inputs; count output; registered head.
  - Instanced twice: entry FIFO and PC tag queue.
- Credit and discard counters live in fetch_queue.

Test Plan:
1. Reset, then imem latency 1 with req_ready = 1 and out_ready = 1 -> out_pc sequence 0x01000000, 0x01000004, 0x01000008; first out_valid 3 cycles after reset deasserts; one entry per cycle thereafter.
2. Hold out_ready = 0 -> exactly 4 entries buffered, req_valid deasserts, nothing lost; release -> entries drain in order, PCs contiguous.
3. imem latency 3 with 3 requests in flight; redirect_pc = 0x01000102 -> 3 responses discarded; next out_pc = 0x01000100; no stale instruction emitted.
4. Redirect in the same cycle as resp_valid and out_ready -> that response dropped; discard = inflight - 1; no pop; FIFO empty next cycle.
5. Two redirects in consecutive cycles (0x200, then 0x300) -> first out_pc = 0x300; no 0x200 entry ever appears.
6. Assert reset mid-stream with 2 entries and 2 in flight -> out_valid = 0 next cycle; fetch restarts at 0x01000000.
